// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: buffers x/w operand pairs, fires the MAC neuron,
// feeds its accumulate window and returns the captured result on valid/ready.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_x/wr_w  operand buffer write (IDLE only, slot < TERMS)
//   go / busy             operation request / in-progress flag
//   mac_start/mac_x/mac_w neuron start pulse and operand stream
//   mac_acc/mac_done      neuron accumulator and done pulse
//   res_valid/res_ready/res_data/res_err  result handshake
//
// Build option: define MAC_SEQ_TIMEOUT_EN to add a watchdog on mac_done
// that completes the operation with res_err=1 after TIMEOUT WAIT cycles.

module mac_operand_sequencer #(
    parameter int TERMS   = 3,
    parameter int DW      = 8,
    parameter int AW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(TERMS)-1:0] wr_addr,
    input  logic [DW-1:0]            wr_x,
    input  logic [DW-1:0]            wr_w,
    input  logic                     go,
    output logic                     busy,
    output logic                     mac_start,
    output logic [DW-1:0]            mac_x,
    output logic [DW-1:0]            mac_w,
    input  logic [AW-1:0]            mac_acc,
    input  logic                     mac_done,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [AW-1:0]            res_data,
    output logic                     res_err
);

    localparam int AB = $clog2(TERMS);
    localparam int CW = $clog2(TERMS + TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_FEED,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [DW-1:0]   op_x [TERMS];
    logic [DW-1:0]   op_w [TERMS];

    logic            busy_d;
    logic            start_d;
    logic [DW-1:0]   x_d, w_d;
    logic            valid_d;
    logic [AW-1:0]   data_d;

    logic            wr_ok;
    assign wr_ok = (state == S_IDLE) && wr_en && (32'(wr_addr) < TERMS);

`ifdef MAC_SEQ_TIMEOUT_EN
    logic err_q, err_d;
    assign res_err = err_q;
`else
    assign res_err = 1'b0;
`endif

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        start_d = 1'b0;
        x_d     = '0;
        w_d     = '0;
        valid_d = res_valid;
        data_d  = res_data;
`ifdef MAC_SEQ_TIMEOUT_EN
        err_d   = err_q;
`endif
        unique case (state)
            S_IDLE: begin
                if (go) begin
                    state_d = S_START;
                    start_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            // Two cycles: the start pulse, then the neuron's clear cycle.
            S_START: begin
                if (cnt == '0) begin
                    cnt_d = cnt + 1'b1;
                end else begin
                    state_d = S_FEED;
                    cnt_d   = '0;
                    x_d     = op_x[0];
                    w_d     = op_w[0];
                end
            end
            // Registered outputs: load the pair for the following cycle.
            S_FEED: begin
                if (cnt == CW'(TERMS - 1)) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                    x_d   = op_x[AB'(cnt + 1'b1)];
                    w_d   = op_w[AB'(cnt + 1'b1)];
                end
            end
            S_WAIT: begin
                if (mac_done) begin
                    state_d = S_HOLD;
                    valid_d = 1'b1;
                    data_d  = mac_acc;
`ifdef MAC_SEQ_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    state_d = S_HOLD;
                    valid_d = 1'b1;
                    data_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
`endif
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            mac_start <= 1'b0;
            mac_x     <= '0;
            mac_w     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
`ifdef MAC_SEQ_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            busy      <= busy_d;
            mac_start <= start_d;
            mac_x     <= x_d;
            mac_w     <= w_d;
            res_valid <= valid_d;
            res_data  <= data_d;
`ifdef MAC_SEQ_TIMEOUT_EN
            err_q     <= err_d;
`endif
        end
    end

    // Operand buffer: written only while idle, never cleared by completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TERMS; i++) begin
                op_x[i] <= '0;
                op_w[i] <= '0;
            end
        end else if (wr_ok) begin
            op_x[wr_addr] <= wr_x;
            op_w[wr_addr] <= wr_w;
        end
    end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// tb_mac_operand_sequencer: drives the sequencer with a behavioural neuron,
// checks every cycle against a cycle-indexed operation model.

module tb_mac_operand_sequencer;

    localparam int TERMS   = 3;
    localparam int DW      = 8;
    localparam int AW      = 16;
    localparam int TIMEOUT = 15;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [1:0]    wr_addr;
    logic [DW-1:0] wr_x, wr_w;
    logic          go;
    logic          busy;
    logic          mac_start;
    logic [DW-1:0] mac_x, mac_w;
    logic [AW-1:0] mac_acc;
    logic          mac_done;
    logic          res_valid;
    logic          res_ready;
    logic [AW-1:0] res_data;
    logic          res_err;

    mac_operand_sequencer #(
        .TERMS(TERMS), .DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_w(wr_w),
        .go(go), .busy(busy),
        .mac_start(mac_start), .mac_x(mac_x), .mac_w(mac_w),
        .mac_acc(mac_acc), .mac_done(mac_done),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural neuron: clear cycle after start, TERMS accumulate
    // cycles, then done with the final accumulator.
    int   n_ph;
    logic force_off;
    logic done_inj;
    logic nrn_done;

    assign nrn_done = (n_ph == TERMS + 2) && !force_off;
    assign mac_done = nrn_done | done_inj;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_ph    <= 0;
            mac_acc <= '0;
        end else if (mac_start) begin
            n_ph    <= 1;
            mac_acc <= '0;
        end else if (n_ph == 1) begin
            n_ph <= 2;
        end else if (n_ph >= 2 && n_ph < TERMS + 2) begin
            mac_acc <= mac_acc + AW'(mac_x) * AW'(mac_w);
            n_ph    <= n_ph + 1;
        end else if (n_ph == TERMS + 2) begin
            n_ph <= 0;
        end
    end

    // Reference model: an operation is "m_act" with m_cyc = cycles since go.
    logic          m_act, m_hold, m_err;
    int            m_cyc;
    logic [AW-1:0] m_res, m_sum;
    logic [DW-1:0] mx [TERMS];
    logic [DW-1:0] mw [TERMS];

    function automatic logic [AW-1:0] dot_with(
        input logic we, input int a,
        input logic [DW-1:0] x, input logic [DW-1:0] w);
        logic [AW-1:0] s;
        s = '0;
        for (int k = 0; k < TERMS; k++) begin
            if (we && a == k) s = s + AW'(x) * AW'(w);
            else              s = s + AW'(mx[k]) * AW'(mw[k]);
        end
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act  <= 1'b0;
            m_hold <= 1'b0;
            m_err  <= 1'b0;
            m_cyc  <= 0;
            m_res  <= '0;
            m_sum  <= '0;
            for (int k = 0; k < TERMS; k++) begin
                mx[k] <= '0;
                mw[k] <= '0;
            end
        end else if (!m_act && !m_hold) begin
            if (wr_en && int'(wr_addr) < TERMS) begin
                mx[wr_addr] <= wr_x;
                mw[wr_addr] <= wr_w;
            end
            if (go) begin
                m_act <= 1'b1;
                m_cyc <= 1;
                m_sum <= dot_with(wr_en, int'(wr_addr), wr_x, wr_w);
            end
        end else if (m_act) begin
            if (m_cyc >= TERMS + 3 && mac_done) begin
                m_act  <= 1'b0;
                m_hold <= 1'b1;
                m_res  <= m_sum;
                m_err  <= 1'b0;
`ifdef MAC_SEQ_TIMEOUT_EN
            end else if (m_cyc - (TERMS + 3) == TIMEOUT - 1) begin
                m_act  <= 1'b0;
                m_hold <= 1'b1;
                m_res  <= '0;
                m_err  <= 1'b1;
`endif
            end else begin
                m_cyc <= m_cyc + 1;
            end
        end else if (res_ready) begin
            m_hold <= 1'b0;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic compare_cycle();
        logic [DW-1:0] ex, ew;
        ex = '0;
        ew = '0;
        if (m_act && m_cyc >= 3 && m_cyc <= TERMS + 2) begin
            ex = mx[m_cyc - 3];
            ew = mw[m_cyc - 3];
        end
        chk("busy", 32'(busy), 32'(m_act || m_hold));
        chk("mac_start", 32'(mac_start), 32'(m_act && m_cyc == 1));
        chk("mac_x", 32'(mac_x), 32'(ex));
        chk("mac_w", 32'(mac_w), 32'(ew));
        chk("res_valid", 32'(res_valid), 32'(m_hold));
        if (m_hold) begin
            chk("res_data", 32'(res_data), 32'(m_res));
            chk("res_err", 32'(res_err), 32'(m_err));
        end
    endtask

    task automatic next();
        @(posedge clk);
        @(negedge clk);
        compare_cycle();
    endtask

    task automatic load(input int a, input int x, input int w);
        wr_en   = 1'b1;
        wr_addr = 2'(a);
        wr_x    = DW'(x);
        wr_w    = DW'(w);
        next();
        wr_en   = 1'b0;
    endtask

    task automatic wait_valid(input int limit);
        int k;
        k = 0;
        while (!res_valid && k < limit) begin
            next();
            k++;
        end
        chk("wait_valid_bound", 32'(res_valid), 32'd1);
    endtask

    task automatic load_base();
        load(0, 2, 3);
        load(1, 4, 5);
        load(2, 6, 7);
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_x      = '0;
        wr_w      = '0;
        go        = 1'b0;
        res_ready = 1'b0;
        force_off = 1'b0;
        done_inj  = 1'b0;

        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_start", 32'(mac_start), 0);
        chk("rst_x", 32'(mac_x), 0);
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_data", 32'(res_data), 0);
        chk("rst_err", 32'(res_err), 0);
        rst_n = 1'b1;
        next();

        // Directed operation with cycle-exact literal expectations.
        load_base();
        go = 1'b1;
        next();
        go = 1'b0;
        chk("lit_start_c1", 32'(mac_start), 1);
        next();
        chk("lit_start_c2", 32'(mac_start), 0);
        next();
        chk("lit_x_c3", 32'(mac_x), 2);
        chk("lit_w_c3", 32'(mac_w), 3);
        next();
        chk("lit_x_c4", 32'(mac_x), 4);
        next();
        chk("lit_w_c5", 32'(mac_w), 7);
        next();
        chk("lit_valid_c6", 32'(res_valid), 0);
        next();
        chk("lit_valid_c7", 32'(res_valid), 1);
        chk("lit_data_c7", 32'(res_data), 68);
        chk("lit_err_c7", 32'(res_err), 0);

        // Result held with ready low; go during HOLD must not restart.
        for (int i = 0; i < 5; i++) begin
            go = 1'b1;
            next();
            chk("lit_hold_start", 32'(mac_start), 0);
            chk("lit_hold_data", 32'(res_data), 68);
            chk("lit_hold_valid", 32'(res_valid), 1);
        end
        go = 1'b0;
        res_ready = 1'b1;
        next();
        chk("lit_after_hs", 32'(res_valid), 0);

        // Same-cycle write and go: the new pair is fed.
        wr_en   = 1'b1;
        wr_addr = 2'd1;
        wr_x    = 8'd10;
        wr_w    = 8'd10;
        go      = 1'b1;
        next();
        wr_en = 1'b0;
        go    = 1'b0;
        wait_valid(20);
        chk("lit_samecyc", 32'(res_data), 148);
        next();
        load(1, 4, 5);

        // Writes while busy and to slot 3 are dropped.
        go = 1'b1;
        next();
        go = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_en   = 1'b1;
            wr_addr = 2'(i);
            wr_x    = 8'd99;
            wr_w    = 8'd99;
            next();
        end
        wr_en = 1'b0;
        wait_valid(20);
        chk("lit_busy_wr", 32'(res_data), 68);
        next();
        load(3, 99, 99);
        go = 1'b1;
        next();
        go = 1'b0;
        wait_valid(20);
        chk("lit_addr3", 32'(res_data), 68);
        next();

        // Reset during FEED.
        go = 1'b1;
        next();
        go = 1'b0;
        next();
        next();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_feed_busy", 32'(busy), 0);
        chk("rst_feed_x", 32'(mac_x), 0);
        chk("rst_feed_w", 32'(mac_w), 0);
        chk("rst_feed_valid", 32'(res_valid), 0);
        chk("rst_feed_data", 32'(res_data), 0);
        #1 rst_n = 1'b1;
        next();
        load_base();
        go = 1'b1;
        next();
        go = 1'b0;
        for (int i = 0; i < 5; i++) next();
        chk("lit_post_rst_c6", 32'(res_valid), 0);
        next();
        chk("lit_post_rst_c7", 32'(res_valid), 1);
        chk("lit_post_rst_data", 32'(res_data), 68);
        next();

        // Neuron never signals done.
        force_off = 1'b1;
        go = 1'b1;
        next();
        go = 1'b0;
`ifdef MAC_SEQ_TIMEOUT_EN
        begin
            int c;
            c = 1;
            while (!res_valid && c < 60) begin
                next();
                c++;
            end
            chk("lit_to_cycle", 32'(c), 32'(TERMS + 3 + TIMEOUT));
            chk("lit_to_err", 32'(res_err), 1);
            chk("lit_to_data", 32'(res_data), 0);
        end
        next();
`else
        for (int i = 0; i < 40; i++) next();
        chk("lit_nodone_busy", 32'(busy), 1);
        chk("lit_nodone_valid", 32'(res_valid), 0);
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        next();
        load_base();
`endif
        force_off = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            wr_en     = ($urandom % 4) == 0;
            wr_addr   = 2'($urandom % 4);
            wr_x      = DW'($urandom);
            wr_w      = DW'($urandom);
            go        = ($urandom % 3) == 0;
            res_ready = ($urandom % 2) == 0;
            done_inj  = (($urandom % 8) == 0) &&
                        !(m_act && m_cyc >= TERMS + 3);
            next();
        end
        done_inj = 1'b0;
        wr_en    = 1'b0;
        go       = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mac_operand_sequencer.md
# mac_operand_sequencer

Initiator-side companion to the MAC neuron. Holds a small buffer of x/w operand pairs, fires the neuron's one-cycle `start`, streams the pairs into the neuron's multiply-accumulate window on the exact cycles it accumulates, and captures the neuron's `acc` when it signals done. The captured result is presented on a valid/ready port to the downstream consumer.

## Interface
- `TERMS`, 3: pairs per MAC operation; must equal the neuron's accumulate-window length.
- `DW`, 8: operand width (x and w).
- `AW`, 16: accumulator/result width.
- `TIMEOUT`, 15: cycles to wait for `mac_done` after the last fed pair (watchdog build only).
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write one operand pair into the buffer.
- `wr_addr`  in  $clog2(TERMS)  buffer slot; values ≥ TERMS ignored.
- `wr_x`, `wr_w`  in  DW each  operand pair to store.
- `go`  in  1  request one MAC operation; accepted only when `busy`=0.
- `busy`  out  1  high from the cycle after an accepted `go` until result handshake completes.
- `mac_start`  out  1  one-cycle start pulse to the neuron.
- `mac_x`, `mac_w`  out  DW each  operand pair to the neuron; 0 outside the feed window.
- `mac_acc`  in  AW  neuron accumulator.
- `mac_done`  in  1  neuron done pulse.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts result.
- `res_data`  out  AW  captured accumulator.
- `res_err`  out  1  result produced by watchdog timeout; `res_data`=0 when set.

## Operation
- States: IDLE, START, FEED, WAIT, HOLD.
- IDLE: `go`=1 → START. Writes are accepted only in IDLE; writes in other states are dropped.
- START: `mac_start`=1 for exactly one cycle. Transitions to FEED with an internal delay of one cycle, matching the neuron's CLEAR cycle.
- FEED: drives `buf[k]` on `mac_x`/`mac_w` for k = 0..TERMS-1, one pair per cycle. After pair TERMS-1, transitions to WAIT.
- WAIT: `mac_done`=1 captures `mac_acc` into `res_data`, sets `res_err`=0, and transitions to HOLD.
- HOLD: `res_valid`=1. When `res_valid`&&`res_ready`, returns to IDLE with `res_valid`=0.
- `mac_done` outside WAIT is ignored.
- `go` while `busy` is ignored and not queued.
- Buffer contents persist across operations and are not cleared by completion.
- Operands pass through bit-exact. No arithmetic is done in this block.
- Same-cycle `wr_en` and `go` in IDLE: the write commits, and the subsequent feed uses the new value.

## Timing
- Reset values: `busy`=0, `mac_start`=0, `mac_x`=`mac_w`=0, `res_valid`=0, `res_data`=0, `res_err`=0, state=IDLE, buffer=0.
- `go` sampled at cycle 0 → `mac_start` high in cycle S=1.
- Pair k is driven in cycle S+2+k.
- `mac_done` is expected in cycle S+2+TERMS.
- `res_valid` rises in the following cycle.
- Minimum go-to-result latency is TERMS+4 cycles.
- Back-to-back: a new `go` is accepted in the cycle after the result handshake.
- `rst_n` low mid-operation asynchronously returns all outputs to reset values and the state to IDLE. The neuron is reset by the same net.
- All outputs are registered.

## Configuration
- `MAC_SEQ_TIMEOUT_EN` defined:
  - A counter runs in WAIT.
  - If `mac_done` is absent for TIMEOUT cycles → HOLD with `res_err`=1 and `res_data`=0.
  - The counter clears on entering WAIT.
- Not defined:
  - WAIT persists until `mac_done` or reset.
  - `res_err` is tied to 0.
  - The `TIMEOUT` parameter is unused.

## Test plan
- Load (2,3),(4,5),(6,7), then `go` with the neuron attached:
  - `mac_start` pulses at cycle 1.
  - Pairs are driven at cycles 3,4,5.
  - `res_valid` at cycle 7 with `res_data`=68 and `res_err`=0.
- Hold `res_ready`=0 for 5 cycles after result 68:
  - `res_valid` and `res_data` are stable.
  - `go` pulses during HOLD produce no `mac_start`.
- `wr_en` slot 1 = (10,10) in the same cycle as `go` (prior contents (2,3),(4,5),(6,7)) → `res_data`=148.
- `MAC_SEQ_TIMEOUT_EN` build with `mac_done` forced 0 → `res_valid` with `res_err`=1 and `res_data`=0, 15 cycles after entering WAIT.
- `rst_n` low during FEED:
  - All outputs go to 0 immediately.
  - After release, a fresh `go` yields 68 with standard latency.
- Writes issued while busy, and `wr_addr`=3, leave the buffer unchanged: the next result is still 68.
